// File: rtl/branch_history_tracker.sv
// Global branch history tracker with an in-order checkpoint FIFO.
// Supplies speculative history at decode, trains the predictor at commit.
module branch_history_tracker #(
    parameter int HIST_W = 2,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_branch,
    input  logic [ADDR_W-1:0] dec_addr,
    input  logic              dec_prediction,
    output logic [HIST_W-1:0] dec_pattern,
    output logic              dec_full,
    output logic [TAG_W-1:0]  dec_tag,
    input  logic              rob_commit,
    input  logic              rob_taken,
    input  logic              rob_mispredict,
    output logic              brp_update,
    output logic [HIST_W-1:0] rob_pattern,
    output logic [ADDR_W-1:0] rob_addr,
    output logic              rob_prediction,
    output logic [TAG_W:0]    count
);

    typedef struct packed {
        logic [HIST_W-1:0] pattern;
        logic [ADDR_W-1:0] addr;
        logic              prediction;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [HIST_W-1:0] spec_hist;
    logic [HIST_W-1:0] arch_hist;
    logic [HIST_W-1:0] arch_next;
    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic              push;
    logic              pop;
    logic              flush;

    assign dec_full    = (count == (TAG_W+1)'(DEPTH));
    assign dec_pattern = spec_hist;
    assign dec_tag     = tail;

    // A mispredict at commit wins over a same-cycle decode push.
    always_comb begin
        pop       = rob_commit & (count != '0);
        flush     = pop & rob_mispredict;
        push      = dec_branch & ~dec_full & ~(rob_commit & rob_mispredict);
        arch_next = {arch_hist[HIST_W-2:0], rob_taken};
    end

    // Checkpoint storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{pattern: spec_hist,
                           addr: dec_addr,
                           prediction: dec_prediction};
        end
    end

    // FIFO pointers and occupancy; a flush empties everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Speculative and architectural history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_hist <= '0;
            arch_hist <= '0;
        end else begin
            if (pop)
                arch_hist <= arch_next;
            if (flush)
                spec_hist <= arch_next;
            else if (push)
                spec_hist <= {spec_hist[HIST_W-2:0], dec_prediction};
        end
    end

    // Registered training port; strobe pulses one cycle after each pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brp_update     <= 1'b0;
            rob_pattern    <= '0;
            rob_addr       <= '0;
            rob_prediction <= 1'b0;
        end else begin
            brp_update <= pop;
            if (pop) begin
                rob_pattern    <= mem[head].pattern;
                rob_addr       <= mem[head].addr;
                rob_prediction <= rob_taken;
            end
        end
    end

endmodule

// File: tb/tb_branch_history_tracker.sv
// Self-checking bench for branch_history_tracker: directed table,
// hand-written corner sequences and random traffic against a queue model.
module tb_branch_history_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_branch;
    logic [5:0] dec_addr;
    logic       dec_prediction;
    logic [1:0] dec_pattern;
    logic       dec_full;
    logic [1:0] dec_tag;
    logic       rob_commit;
    logic       rob_taken;
    logic       rob_mispredict;
    logic       brp_update;
    logic [1:0] rob_pattern;
    logic [5:0] rob_addr;
    logic       rob_prediction;
    logic [2:0] count;

    int errors = 0;
    int checks = 0;

    branch_history_tracker dut (
        .clk(clk),
        .rst(rst),
        .dec_branch(dec_branch),
        .dec_addr(dec_addr),
        .dec_prediction(dec_prediction),
        .dec_pattern(dec_pattern),
        .dec_full(dec_full),
        .dec_tag(dec_tag),
        .rob_commit(rob_commit),
        .rob_taken(rob_taken),
        .rob_mispredict(rob_mispredict),
        .brp_update(brp_update),
        .rob_pattern(rob_pattern),
        .rob_addr(rob_addr),
        .rob_prediction(rob_prediction),
        .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of in-flight branches plus plain integers.
    typedef struct {
        int pat;
        int addr;
        int pred;
    } ent_t;

    ent_t m_q[$];
    int   m_spec, m_arch, m_tail;
    int   m_upd, m_upat, m_uaddr, m_upred;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_spec = 0;
        m_arch = 0;
        m_tail = 0;
        m_upd  = 0;
        m_upat = 0;
        m_uaddr = 0;
        m_upred = 0;
    endtask

    task automatic model_step(input int b, input int a, input int p,
                              input int c, input int t, input int m);
        bit   full, push, pop;
        ent_t e;
        full = (m_q.size() == 4);
        push = b && !full && !(c && m);
        pop  = c && (m_q.size() > 0);
        m_upd = pop;
        if (pop) begin
            e = m_q.pop_front();
            m_upat  = e.pat;
            m_uaddr = e.addr;
            m_upred = t;
            m_arch  = ((m_arch * 2) + t) % 4;
        end
        if (pop && m) begin
            m_q.delete();
            m_tail = 0;
            m_spec = m_arch;
        end else if (push) begin
            e.pat  = m_spec;
            e.addr = a;
            e.pred = p;
            m_q.push_back(e);
            m_tail = (m_tail + 1) % 4;
            m_spec = ((m_spec * 2) + p) % 4;
        end
    endtask

    task automatic drive(input int b, input int a, input int p,
                         input int c, input int t, input int m);
        dec_branch     = 1'(b);
        dec_addr       = 6'(a);
        dec_prediction = 1'(p);
        rob_commit     = 1'(c);
        rob_taken      = 1'(t);
        rob_mispredict = 1'(m);
    endtask

    task automatic check_model();
        chk("pattern", int'(dec_pattern), m_spec);
        chk("count", int'(count), m_q.size());
        chk("full", int'(dec_full), int'(m_q.size() == 4));
        chk("tag", int'(dec_tag), m_tail);
        chk("upd", int'(brp_update), m_upd);
        if (m_upd != 0) begin
            chk("upd_pat", int'(rob_pattern), m_upat);
            chk("upd_addr", int'(rob_addr), m_uaddr);
            chk("upd_pred", int'(rob_prediction), m_upred);
        end
    endtask

    // One clock: drive after the edge, update model, check #1 after next edge.
    task automatic step(input int b, input int a, input int p,
                        input int c, input int t, input int m);
        drive(b, a, p, c, t, m);
        @(posedge clk);
        model_step(b, a, p, c, t, m);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        int b, a, p, c, t, m;
        int pat, cnt, tag, upd, upat, uaddr, upred;
    } vec_t;

    vec_t tbl[7];

    initial begin
        // Directed vectors: expected values after the clock edge.
        tbl[0] = '{1, 5, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
        tbl[1] = '{1, 6, 1, 0, 0, 0, 3, 2, 2, 0, 0, 0, 0};
        tbl[2] = '{1, 7, 0, 0, 0, 0, 2, 3, 3, 0, 0, 0, 0};
        tbl[3] = '{0, 0, 0, 1, 1, 0, 2, 2, 3, 1, 0, 5, 1};
        tbl[4] = '{0, 0, 0, 1, 1, 0, 2, 1, 3, 1, 1, 6, 1};
        tbl[5] = '{0, 0, 0, 1, 0, 0, 2, 0, 3, 1, 3, 7, 0};
        tbl[6] = '{0, 0, 0, 0, 0, 0, 2, 0, 3, 0, 0, 0, 0};

        do_reset();
        chk("rst_pattern", int'(dec_pattern), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_tag", int'(dec_tag), 0);
        chk("rst_upd", int'(brp_update), 0);
        chk("rst_full", int'(dec_full), 0);

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].b, tbl[i].a, tbl[i].p,
                  tbl[i].c, tbl[i].t, tbl[i].m);
            @(posedge clk);
            model_step(tbl[i].b, tbl[i].a, tbl[i].p,
                       tbl[i].c, tbl[i].t, tbl[i].m);
            #1;
            chk("tbl_pattern", int'(dec_pattern), tbl[i].pat);
            chk("tbl_count", int'(count), tbl[i].cnt);
            chk("tbl_tag", int'(dec_tag), tbl[i].tag);
            chk("tbl_upd", int'(brp_update), tbl[i].upd);
            if (tbl[i].upd != 0) begin
                chk("tbl_upat", int'(rob_pattern), tbl[i].upat);
                chk("tbl_uaddr", int'(rob_addr), tbl[i].uaddr);
                chk("tbl_upred", int'(rob_prediction), tbl[i].upred);
            end
        end

        // Fill to four, then a fifth push while full is dropped.
        step(1, 10, 1, 0, 0, 0);
        step(1, 11, 0, 0, 0, 0);
        step(1, 12, 1, 0, 0, 0);
        step(1, 13, 1, 0, 0, 0);
        chk("full_flag", int'(dec_full), 1);
        step(1, 14, 0, 0, 0, 0);
        chk("full_count", int'(count), 4);
        chk("full_spec", int'(dec_pattern), 3);

        // Architectural history 10 -> 01, leaving three in flight.
        step(0, 0, 0, 1, 1, 0);
        chk("pre_mis_count", int'(count), 3);

        // Mispredict with taken=0 and a same-cycle decode push.
        step(1, 20, 1, 1, 0, 1);
        chk("mis_count", int'(count), 0);
        chk("mis_spec", int'(dec_pattern), 2);
        chk("mis_upd", int'(brp_update), 1);
        chk("mis_uaddr", int'(rob_addr), 11);
        chk("mis_upat", int'(rob_pattern), 1);
        chk("mis_upred", int'(rob_prediction), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("mis_pulse_end", int'(brp_update), 0);

        // Commit on an empty FIFO is ignored.
        step(0, 0, 0, 1, 1, 0);
        chk("empty_upd", int'(brp_update), 0);
        chk("empty_count", int'(count), 0);

        // Two in flight, then six simultaneous push/pop cycles wrap pointers.
        step(1, 30, 1, 0, 0, 0);
        step(1, 31, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            step(1, 32 + i, i % 2, 1, (i / 2) % 2, 0);
        chk("wrap_count", int'(count), 2);
        chk("wrap_tag", int'(dec_tag), 0);

        // Reset mid-stream with three entries and an update pending.
        step(1, 40, 1, 0, 0, 0);
        step(1, 41, 0, 1, 1, 0);
        chk("pre_rst_upd", int'(brp_update), 1);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_upd", int'(brp_update), 0);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_pattern", int'(dec_pattern), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(int'($urandom_range(0, 99) < 60),
                 int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 99) < 45),
                 int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 99) < 12));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_history_tracker.md
Name: branch_history_tracker

Overview:
Maintains global branch history for the 2-bit-counter branch predictor and drives its training port. On the decode side it supplies the speculative history pattern used for prediction lookup and records each predicted branch in an in-order checkpoint FIFO. On the commit side it pops the oldest entry when the ROB retires a branch, issues a registered predictor update with the actual outcome, and restores speculative history on mispredict.

Parameters:
HIST_W, 2, global history width; equals the predictor's history width
ADDR_W, 6, branch PC index bits; equals the predictor's address width
DEPTH, 4, checkpoint FIFO entries (power of 2)
TAG_W, 2, log2(DEPTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
dec_branch  in  1  decoder issues a conditional branch this cycle
dec_addr  in  ADDR_W  branch PC index bits
dec_prediction  in  1  predictor's taken bit for {dec_pattern, dec_addr}
dec_pattern  out  HIST_W  speculative history; combinational from the history register
dec_full  out  1  FIFO full; decoder must stall branches
dec_tag  out  TAG_W  FIFO slot of the branch accepted this cycle (current tail pointer)
rob_commit  in  1  ROB retires the oldest in-flight branch
rob_taken  in  1  actual outcome of the retiring branch
rob_mispredict  in  1  retiring branch was mispredicted; qualified by rob_commit
brp_update  out  1  predictor training strobe
rob_pattern  out  HIST_W  history used at prediction time
rob_addr  out  ADDR_W  PC index of the trained branch
rob_prediction  out  1  training direction (actual outcome: 1 = increment counter)
count  out  TAG_W+1  in-flight branch count

Behaviour:
- Reset (asynchronous, active-high): spec_hist=0, arch_hist=0, head=tail=0, count=0, brp_update=0, rob_pattern=0, rob_addr=0, rob_prediction=0. Reset mid-operation discards all entries immediately.
- FIFO entry holds {pattern, addr, prediction}. dec_full = (count == DEPTH).
- Push occurs when dec_branch & !dec_full & !(rob_commit & rob_mispredict).
  - Writes {spec_hist, dec_addr, dec_prediction} at tail.
  - tail++ with wrap mod DEPTH.
  - spec_hist <= {spec_hist[HIST_W-2:0], dec_prediction}.
- Push is dropped when full. Push is also dropped on a same-cycle mispredict; mispredict wins.
- Pop occurs when rob_commit & count != 0. rob_commit on an empty FIFO is ignored: no update, no state change.
  - arch_hist <= {arch_hist[HIST_W-2:0], rob_taken}.
  - Next cycle: brp_update=1, rob_pattern=head.pattern, rob_addr=head.addr, rob_prediction=rob_taken.
  - head++ with wrap.
- brp_update is a 1-cycle pulse, one cycle after each pop. It is 0 in any cycle not following a pop. Back-to-back pops give back-to-back pulses.
- Mispredict (pop with rob_mispredict=1):
  - Flush all entries: head=tail=0, count=0.
  - spec_hist <= {arch_hist[HIST_W-2:0], rob_taken}, the updated architectural history.
  - The update pulse for the popped branch is still issued.
- Simultaneous push and pop without mispredict: both proceed and count is unchanged. Fullness is judged on the pre-cycle count, so a push while full is dropped even if a pop occurs the same cycle.
- count = pushes - pops, saturating within 0..DEPTH by construction.
- rob_mispredict without rob_commit is ignored.

Test Plan:
- Reset, then 3 pushes with predictions 1,1,0 and addrs 5,6,7 -> dec_pattern goes 00,01,11,10; dec_tag 0,1,2; count=3.
- From the state above, commit 3 branches with taken=1,1,0 and no mispredict -> brp_update pulses on cycles c+1..c+3 with (pattern,addr,pred) = (00,5,1),(01,6,1),(11,7,0); count=0; arch_hist=10.
- 4 pushes, then a 5th push while full -> dec_full=1; 5th ignored; count stays 4; spec_hist unchanged on 5th cycle.
- arch_hist=01, 3 entries in flight, commit with taken=0 and mispredict=1, plus dec_branch same cycle -> count=0; spec_hist=10; push dropped; one update pulse with the head entry.
- Empty FIFO, rob_commit=1 -> no brp_update; count=0. Then simultaneous push and pop on count=2 -> count stays 2; pointers wrap correctly across DEPTH boundary after 6 such cycles.
- Assert rst mid-stream with 3 entries and an update pending -> brp_update=0 immediately; count=0; dec_pattern=00.
